// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single four-bank main memory between the I-cache and
//            D-cache miss controllers. One owner at a time, round-robin on
//            ties, no preemption. Read returns are routed by a tag pipeline so
//            data reaches the side that issued the read even after handoff.
//            A sticky error flag records illegal accesses, starvation and
//            corrupted FSM state.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  // I-side requester
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic        i_wr,
  input  logic        i_rd,
  // D-side requester
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        d_wr,
  input  logic        d_rd,
  // grants and handshakes back to requesters
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        i_wait,
  output logic        d_wait,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic [15:0] i_rdata,
  output logic [15:0] d_rdata,
  // memory side
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  // sticky error
  output logic        err
);

  localparam int                  c_HOLD_W   = $clog2(MAX_HOLD) + 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic                r_last;     // 0: I was the most recent owner, 1: D
  logic                r_i_gnt;
  logic                r_d_gnt;
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_err;
  logic [RD_LAT-1:0]   r_tag_v;    // return slot carries an accepted read
  logic [RD_LAT-1:0]   r_tag_d;    // return slot belongs to D (else I)

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  state_t      w_arb;        // winner when the grant is up for grabs
  state_t      w_state_nxt;
  logic        w_bad_state;
  logic        w_own_i;
  logic        w_own_d;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_wdata;
  logic        w_sel_wr;
  logic        w_sel_rd;
  logic        w_illegal;
  logic        w_push_v;
  logic        w_other_req;
  logic        w_hold_run;
  logic        w_hold_err;

  assign w_own_i = (r_state == ST_OWN_I);
  assign w_own_d = (r_state == ST_OWN_D);

  // Arbitration among current requests; ties go to the side that did not own last.
  always_comb begin
    w_arb = ST_IDLE;
    case ({i_req, d_req})
      2'b10:   w_arb = ST_OWN_I;
      2'b01:   w_arb = ST_OWN_D;
      2'b11:   w_arb = r_last ? ST_OWN_I : ST_OWN_D;
      default: w_arb = ST_IDLE;
    endcase
  end

  // Next state: an owner keeps the grant for as long as it requests.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_bad_state = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_arb;
      ST_OWN_I: w_state_nxt = i_req ? ST_OWN_I : w_arb;
      ST_OWN_D: w_state_nxt = d_req ? ST_OWN_D : w_arb;
      default: begin
        w_state_nxt = ST_IDLE;
        w_bad_state = 1'b1;
      end
    endcase
  end

  // Owner mux onto memory; simultaneous wr+rd from the owner kills both strobes.
  always_comb begin
    w_sel_addr  = 16'h0000;
    w_sel_wdata = 16'h0000;
    w_sel_wr    = 1'b0;
    w_sel_rd    = 1'b0;
    case (r_state)
      ST_OWN_I: begin
        w_sel_addr  = i_addr;
        w_sel_wdata = i_wdata;
        w_sel_wr    = i_wr;
        w_sel_rd    = i_rd;
      end
      ST_OWN_D: begin
        w_sel_addr  = d_addr;
        w_sel_wdata = d_wdata;
        w_sel_wr    = d_wr;
        w_sel_rd    = d_rd;
      end
      default: ;
    endcase
    w_illegal = w_sel_wr & w_sel_rd;
  end

  assign mem_addr  = w_sel_addr;
  assign mem_wdata = w_sel_wdata;
  assign mem_wr    = w_sel_wr & ~w_illegal;
  assign mem_rd    = w_sel_rd & ~w_illegal;

  // A read is only tagged once memory has actually taken it.
  assign w_push_v = mem_rd & ~mem_stall;

  // Starvation watch: the non-owner is asking and the owner is staying put.
  assign w_other_req = (w_own_i & d_req) | (w_own_d & i_req);
  assign w_hold_run  = w_other_req & (w_state_nxt == r_state);
  assign w_hold_err  = (r_hold == c_HOLD_MAX);

  // --------------------------------------------------------------------------
  // Ownership FSM with registered grants and round-robin history.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b0;
      r_i_gnt <= 1'b0;
      r_d_gnt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i_gnt <= (w_state_nxt == ST_OWN_I);
      r_d_gnt <= (w_state_nxt == ST_OWN_D);
      if (w_state_nxt == ST_OWN_I) begin
        r_last <= 1'b0;
      end else if (w_state_nxt == ST_OWN_D) begin
        r_last <= 1'b1;
      end
    end
  end

  // Hold counter: saturates at MAX_HOLD, clears on handoff or when nobody waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_hold_run) begin
      if (r_hold != c_HOLD_MAX) begin
        r_hold <= r_hold + c_HOLD_ONE;
      end
    end else begin
      r_hold <= '0;
    end
  end

  // Return-tag shift register; its tail says who owns this cycle's mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      r_tag_d <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag_d[k] <= r_tag_d[k-1];
      end
      r_tag_v[0] <= w_push_v;
      r_tag_d[0] <= w_own_d;
    end
  end

  // Sticky error collector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_illegal | w_hold_err | w_bad_state;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign i_gnt    = r_i_gnt;
  assign d_gnt    = r_d_gnt;
  assign i_wait   = i_req & (~r_i_gnt | mem_stall);
  assign d_wait   = d_req & (~r_d_gnt | mem_stall);
  assign i_rvalid = r_tag_v[RD_LAT-1] & ~r_tag_d[RD_LAT-1];
  assign d_rvalid = r_tag_v[RD_LAT-1] &  r_tag_d[RD_LAT-1];
  assign i_rdata  = i_rvalid ? mem_rdata : 16'h0000;
  assign d_rdata  = d_rvalid ? mem_rdata : 16'h0000;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single four-bank main memory between the instruction-cache and data-cache controllers. Each controller keeps its memory request asserted for its entire miss sequence (write-back plus fill). The arbiter grants one owner at a time and muxes that owner's address, data and control onto memory. Because reads return after a fixed latency, it also steers returned read data back to the requester that issued each read, even after ownership has moved on.

## Interface
Parameters:
- RD_LAT, 2, memory read latency in cycles from accepted `mem_rd` to valid `mem_rdata`
- MAX_HOLD, 16, cycles one owner may hold the grant while the other waits before `err` is raised

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-side requests memory ownership; held high for the whole miss sequence
- i_addr  in  16  I-side address
- i_wdata  in  16  I-side write data
- i_wr, i_rd  in  1 each  I-side write/read strobes
- d_req, d_addr, d_wdata, d_wr, d_rd  in  1/16/16/1/1  D-side equivalents
- i_gnt, d_gnt  out  1 each  ownership grant; at most one high
- i_wait, d_wait  out  1 each  requester must hold its current access
- i_rvalid, d_rvalid  out  1 each  `mem_rdata` belongs to this side this cycle
- i_rdata, d_rdata  out  16 each  `mem_rdata` when the matching rvalid is high, else 0
- mem_addr, mem_wdata  out  16 each  muxed to memory
- mem_wr, mem_rd  out  1 each  muxed strobes
- mem_rdata  in  16  memory read data
- mem_stall  in  1  memory did not accept this cycle's access
- err  out  1  sticky error flag; cleared only by `rst`

## Operation
- FSM states: IDLE, OWN_I, OWN_D. Both grants are Moore outputs: `i_gnt` = (state == OWN_I), `d_gnt` = (state == OWN_D).
- Transitions out of IDLE, and out of OWN_x when x_req = 0:
  - exactly one req high: go to that side;
  - both reqs high: go to the side that is not `last` (round-robin);
  - no req: go to IDLE.
- OWN_x with x_req = 1: stay in OWN_x. There is no preemption.
- `last` register: set to the new owner on every entry into OWN_I or OWN_D. Reset value is I, so D wins the first tie.
- Mux behaviour:
  - In OWN_x, `mem_addr`, `mem_wdata`, `mem_wr` and `mem_rd` carry x's signals.
  - In IDLE, all four are 0.
  - Non-owner strobes are ignored.
- Illegal access: if the owner drives wr and rd in the same cycle, both memory strobes are forced to 0 and `err` is set.
- Wait signals: `x_wait` = x_req & (~x_gnt | mem_stall).
- Return-tag pipeline: an RD_LAT-deep shift register of {valid, owner}.
  - Pushes valid = mem_rd & ~mem_stall, owner = current owner.
  - Its output stage drives `i_rvalid` / `d_rvalid`.
  - Returned reads are routed by tag, not by the current grant, so a read issued by the old owner still reaches it after a switch.
- Hold counter (width clog2(MAX_HOLD)+1):
  - counts cycles while the state is OWN_x and the other req is high;
  - clears on any state change or when the other req is low;
  - when it reaches MAX_HOLD, `err` is set. Grant is unaffected.
- Undefined state encoding: go to IDLE next cycle and set `err`.

## Timing
- Reset values: state IDLE; `last` = I; both gnt 0; tag pipe all invalid; hold counter 0; `err` 0.
- All outputs are at their reset values in the cycle after `rst` is sampled high.
- Grant latency: a req sampled high at edge t from IDLE gives gnt high during cycle t+1.
- Handoff: owner drops req at edge t and the other req is high → the other side's gnt is high in cycle t+1. There is no dead cycle.
- Read return: an access accepted in cycle t (mem_rd & ~mem_stall) gives x_rvalid high in cycle t+RD_LAT.
- Writes produce no return.
- Stalled access (mem_stall = 1): no tag is pushed, and the requester sees wait and repeats the access next cycle.
- Reset mid-burst: tags are flushed, so data returning after reset asserts no rvalid. Grants drop immediately.
- `err` is registered and rises the cycle after its cause.

## Test plan
- I-only fill: after reset, i_req = 1; four reads to 0x0010–0x0016 on consecutive cycles → i_gnt high from cycle 1, i_rvalid high in cycles 3–6 carrying memory data, d_rvalid = 0 throughout.
- Tie after reset: i_req and d_req rise together → d_gnt first. D drops req → i_gnt next cycle. Tie again after I releases → D granted (it is not `last`).
- Handoff with in-flight reads: D issues reads in its last two cycles, then drops req while I waits → i_gnt next cycle, and the two returns assert d_rvalid (not i_rvalid) with data 0xBEEF and 0xCAFE.
- Memory stall: mem_stall = 1 for 2 cycles during an I read → i_wait = 1, no tag pushed, exactly one i_rvalid per accepted read.
- Errors:
  - owner asserts wr and rd together → mem_wr = mem_rd = 0, err = 1 next cycle;
  - separately, D holds the grant 16 cycles while I waits → err = 1 and d_gnt is unchanged.
- Reset mid-burst: rst asserted one cycle after a D read is accepted → gnts 0, no rvalid two cycles later, err = 0.
